// File: rtl/system_motor_pwm_pkg.sv
// rtl/system_motor_pwm_pkg.sv - state encoding, register map and CTRL fields for the motor PWM block
package system_motor_pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RAMP  = 2'd1,
      ST_RUN   = 2'd2,
      ST_BRAKE = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_PERIOD = 2'd0;
   localparam logic [1:0] ADDR_TARGET = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_DIR_BIT  = 1;
   localparam int CTRL_STEP_LSB = 8;
   localparam int CTRL_STEP_W   = 8;

   localparam int STATUS_DUTY_LSB = 16;

endpackage

// File: rtl/system_motor_pwm_if.sv
// rtl/system_motor_pwm_if.sv - Avalon-style register port for the motor PWM block
interface system_motor_pwm_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, output chipselect, output write_n, output writedata, input readdata);
   modport slave  (input address, input chipselect, input write_n, input writedata, output readdata);
endinterface

// File: rtl/system_motor_pwm_cnt.sv
// rtl/system_motor_pwm_cnt.sv - PWM period counter with period boundary pulse
module system_motor_pwm_cnt #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic [DW-1:0] period,
   output logic [DW-1:0] cnt,
   output logic          boundary
);

   // Boundary on the last count, or immediately when a shrunk PERIOD leaves cnt out of range
   always_comb begin
      boundary = !clr && (period != '0) && (cnt >= period - DW'(1));
   end

   // Count up and wrap at the boundary; a zero period parks the counter at 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr || (period == '0) || boundary) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DW'(1);
      end
   end

endmodule

// File: rtl/system_motor_pwm.sv
// rtl/system_motor_pwm.sv - ramped motor PWM with direction-safe braking and register access
module system_motor_pwm #(
   parameter int DW         = 16,
   parameter int PERIOD_RST = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   system_motor_pwm_if.slave avs,
   input  logic              motor_rst,
   output logic              pwm_out,
   output logic              dir_out,
   output logic              en_out
);
   import system_motor_pwm_pkg::*;

   logic [DW-1:0]          period_r;
   logic [DW-1:0]          target_r;
   logic                   ctrl_en;
   logic                   ctrl_dir;
   logic [CTRL_STEP_W-1:0] ctrl_step;
   logic [DW-1:0]          duty_cur;
   logic [DW-1:0]          cnt;
   logic                   boundary;
   logic [DW-1:0]          eff_target;
   logic [DW-1:0]          goal;
   logic [DW-1:0]          diff;
   logic [DW-1:0]          step_ext;
   logic [DW-1:0]          duty_next;
   logic                   wr;
   logic                   load_dir;
   state_t                 state;
   state_t                 state_nxt;
   logic                   unused_wdata;

   assign wr           = avs.chipselect && !avs.write_n;
   assign unused_wdata = &{1'b0, avs.writedata};

   system_motor_pwm_cnt #(.DW(DW)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (motor_rst),
      .period   (period_r),
      .cnt      (cnt),
      .boundary (boundary)
   );

   // Host register file; motor_rst holds the enable bit low but other fields still accept writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_r  <= DW'(PERIOD_RST);
         target_r  <= '0;
         ctrl_en   <= 1'b0;
         ctrl_dir  <= 1'b0;
         ctrl_step <= '0;
      end else begin
         if (wr && (avs.address == ADDR_PERIOD)) period_r <= avs.writedata[DW-1:0];
         if (wr && (avs.address == ADDR_TARGET)) target_r <= avs.writedata[DW-1:0];
         if (wr && (avs.address == ADDR_CTRL)) begin
            ctrl_dir  <= avs.writedata[CTRL_DIR_BIT];
            ctrl_step <= avs.writedata[CTRL_STEP_LSB +: CTRL_STEP_W];
         end
         if (motor_rst) ctrl_en <= 1'b0;
         else if (wr && (avs.address == ADDR_CTRL)) ctrl_en <= avs.writedata[CTRL_EN_BIT];
      end
   end

   // Zero-latency readback, unused bits read as 0
   always_comb begin
      avs.readdata = '0;
      case (avs.address)
         ADDR_PERIOD: avs.readdata[DW-1:0] = period_r;
         ADDR_TARGET: avs.readdata[DW-1:0] = target_r;
         ADDR_CTRL: begin
            avs.readdata[CTRL_EN_BIT]                  = ctrl_en;
            avs.readdata[CTRL_DIR_BIT]                 = ctrl_dir;
            avs.readdata[CTRL_STEP_LSB +: CTRL_STEP_W] = ctrl_step;
         end
         default: begin
            avs.readdata[1:0]                   = state;
            avs.readdata[STATUS_DUTY_LSB +: DW] = duty_cur;
         end
      endcase
   end

   // Ramp goal clamps to PERIOD (full duty); braking heads to 0; stepping saturates at the goal
   always_comb begin
      eff_target = (target_r > period_r) ? period_r : target_r;
      goal       = (state == ST_BRAKE) ? '0 : eff_target;
      diff       = (goal > duty_cur) ? (goal - duty_cur) : (duty_cur - goal);
      step_ext   = DW'(ctrl_step);
      if ((ctrl_step == '0) || (diff <= step_ext)) duty_next = goal;
      else if (goal > duty_cur)                    duty_next = duty_cur + step_ext;
      else                                         duty_next = duty_cur - step_ext;
   end

   // Duty moves only at boundaries; pwm is a registered compare; direction loads only at zero duty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_cur <= '0;
         pwm_out  <= 1'b0;
         dir_out  <= 1'b0;
      end else begin
         if (motor_rst) duty_cur <= '0;
         else if (boundary && (state != ST_IDLE)) duty_cur <= duty_next;
         pwm_out <= !motor_rst && (state != ST_IDLE) && (period_r != '0) && (cnt < duty_cur);
         if (load_dir) dir_out <= ctrl_dir;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: soft reset wins, then brake on disable or reversal request
   always_comb begin
      state_nxt = state;
      if (motor_rst) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (ctrl_en) state_nxt = ST_RAMP;
            ST_RAMP: begin
               if (!ctrl_en || (ctrl_dir != dir_out)) state_nxt = ST_BRAKE;
               else if (duty_cur == goal)             state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (!ctrl_en || (ctrl_dir != dir_out)) state_nxt = ST_BRAKE;
               else if (duty_cur != goal)             state_nxt = ST_RAMP;
            end
            ST_BRAKE: if (duty_cur == '0) state_nxt = ctrl_en ? ST_RAMP : ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs: bridge enabled outside IDLE; direction latched when entering RAMP from rest
   always_comb begin
      en_out   = (state != ST_IDLE);
      load_dir = (state_nxt == ST_RAMP) && ((state == ST_IDLE) || (state == ST_BRAKE));
   end

endmodule
